rc5_key_expand_16bit: RTL and testbench
=======================================

RC5_KEY_EXPAND_16BIT -- requirements
Module: rc5_key_expand_16bit

Interface
REQ-001 SHALL have parameter ROUNDS, default 12: RC5 round count; subkey count T = 2*(ROUNDS+1) = 26.
REQ-002 SHALL have parameter KEY_BYTES, default 4: secret key length b in bytes; C = KEY_BYTES = 4 L-words, since u = 1.
REQ-003 SHALL have port clock, input, 1 bit: single clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port key_start, input, 1 bit: request expansion of key.
REQ-006 SHALL have port key, input, 8*KEY_BYTES bits: secret key; byte K[j] = key[8j+7:8j].
REQ-007 SHALL have port key_busy, output, 1 bit: expansion in progress.
REQ-008 SHALL have port key_valid, output, 1 bit: the S table is complete and stable.
REQ-009 SHALL have port s_rd_addr, input, 5 bits: subkey read index from the downstream rc5_enc_16bit.
REQ-010 SHALL have port s_rd_data, output, 8 bits: S[s_rd_addr], combinational read.

Function
REQ-011 SHALL implement the RC5-8 key schedule with w = 8, P8 = 0xB7, Q8 = 0x9F, and all arithmetic mod 256.
REQ-012 SHALL use a FSM with states IDLE, INIT, MIX and DONE.
REQ-013 SHALL, in IDLE or DONE with key_start = 1, do the following at that edge: latch key into L[0..C-1] (L[j] = K[j]), clear i, j, A and B, clear key_valid, and go to INIT.
REQ-014 SHALL, in INIT, write one entry per cycle, S[i] = 0xB7 + i*0x9F, with i counting 0..T-1; after S[T-1] is written, clear i and go to MIX.
REQ-015 SHALL, in MIX, perform one iteration per cycle for 3*max(T,C) = 78 iterations:
  - A' = rotl8(S[i]+A+B, 3); S[i] = A'.
  - B' = rotl8(L[j]+A'+B, (A'+B) mod 8); L[j] = B'.
  - B' uses the same-cycle A'.
  - i wraps T-1 -> 0; j wraps C-1 -> 0.
REQ-016 SHALL, after the 78th MIX iteration, go to DONE and set key_valid = 1.
REQ-017 SHALL treat a rotate amount of 0 as identity.
REQ-018 SHALL have latency: key_valid high exactly 104 edges after the edge sampling key_start (1 + 26 + 78 - 1 = 104).
REQ-019 SHALL drive key_busy = 1 exactly in INIT and MIX, and key_valid = 1 exactly in DONE.
REQ-020 SHALL ignore key_start while key_busy = 1; the key is not re-latched and the timing is unchanged.
REQ-021 SHALL treat key_start in DONE as a rekey: key_valid falls on the next edge.
REQ-022 SHALL make changes on key after the latching edge have no effect.
REQ-023 SHALL return 0x00 on s_rd_data for s_rd_addr >= T.
REQ-024 SHALL return in-progress S values during INIT and MIX; the consumer uses S only while key_valid = 1.
REQ-025 SHALL hold the S table unchanged in DONE until the next accepted key_start or reset.

Reset
REQ-026 SHALL, on reset = 1 at a rising edge, do the following regardless of state:
  - go to IDLE.
  - set key_busy = 0 and key_valid = 0.
  - clear i, j, A, B, L[] and S[] to 0.
REQ-027 SHALL give reset priority over key_start in the same cycle.
REQ-028 SHALL abort an expansion on reset mid-INIT or mid-MIX; no partial key_valid is produced.
REQ-029 SHALL drive s_rd_data = 0x00 for all addresses after reset.

Structure
REQ-030 SHALL have package rc5_pkg hold P8, Q8, ROUNDS, T, C, MIX_ITERS = 78 and the FSM state enum; rc5_enc_16bit shares the same package.
REQ-031 SHALL have one sub-module, rc5_rotl8: combinational 8-bit rotate-left by a 3-bit amount, instantiated twice, for A and B.
REQ-032 SHALL implement S as a 26x8 register array, not SRAM, to allow the combinational read port.

Verification
REQ-033 SHALL cover: reset, then key_start = 1 for 1 cycle with key = 0x00000000 -> key_busy rises next edge; key_valid rises exactly 104 edges after start; all 26 S entries equal the bench software RC5-8 model.
REQ-034 SHALL cover: key = 0x03020100 -> after INIT (probe at 27 edges), S[0] = 0xB7, S[1] = 0x56, S[25] = 0x3E; final S[0..25] matches the model.
REQ-035 SHALL cover: a second key_start pulse at cycle 50 of a run with key changed to 0xFFFFFFFF -> ignored; the result is still that of the original key; key_valid at edge 104.
REQ-036 SHALL cover: reset asserted in MIX at cycle 60 -> the next edge gives IDLE, key_busy = 0, key_valid = 0, and s_rd_data = 0x00 for addresses 0..25.
REQ-037 SHALL cover: s_rd_addr = 26 and 31 while in DONE -> s_rd_data = 0x00.
REQ-038 SHALL cover: key_start in DONE with a new key 0x12345678 -> key_valid drops next edge, re-rises 104 edges later; S matches the model for the new key; an rc5_enc_16bit instance fed by this block encrypts 0x0000 to the model ciphertext.

Source files
------------

// File: rtl/rc5_pkg.sv
// Shared RC5-8 constants and FSM state type for the key-expansion and
// encryption blocks.
package rc5_pkg;

   localparam int         ROUNDS    = 12;
   localparam int         T         = 2 * (ROUNDS + 1);
   localparam int         KEY_BYTES = 4;
   localparam int         C         = KEY_BYTES;
   localparam int         MIX_ITERS = 3 * ((T > C) ? T : C);
   localparam logic [7:0] P8        = 8'hB7;
   localparam logic [7:0] Q8        = 8'h9F;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      MIX  = 2'd2,
      DONE = 2'd3
   } key_state_e;

endpackage

// File: rtl/rc5_enc_16bit.sv
// Iterative RC5-8 encryptor for a 16-bit block; fetches one subkey per clock
// from the key-expansion read port.
module rc5_enc_16bit
   import rc5_pkg::*;
#(
   parameter int NR = rc5_pkg::ROUNDS
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enc_start,
   input  logic [15:0] pt,
   output logic [4:0]  s_rd_addr,
   input  logic [7:0]  s_rd_data,
   output logic        enc_busy,
   output logic        ct_valid,
   output logic [15:0] ct
);

   localparam logic [4:0] K_LAST = 5'(2 * (NR + 1) - 1);

   logic        busy_q, busy_d;
   logic        ct_valid_q, ct_valid_d;
   logic [4:0]  k_q, k_d;
   logic [7:0]  a_q, a_d;
   logic [7:0]  b_q, b_d;
   logic [15:0] ct_q, ct_d;
   logic [7:0]  rot_in_s, rot_out_s;
   logic [2:0]  rot_amt_s;

   always_comb begin
      rot_in_s  = a_q ^ b_q;
      rot_amt_s = k_q[0] ? a_q[2:0] : b_q[2:0];
   end

   rc5_rotl8 u_rotl (
      .din  (rot_in_s),
      .amt  (rot_amt_s),
      .dout (rot_out_s)
   );

   // Steps 0/1 whiten A/B; afterwards even steps update A, odd steps update B.
   always_comb begin
      busy_d     = busy_q;
      ct_valid_d = ct_valid_q;
      k_d        = k_q;
      a_d        = a_q;
      b_d        = b_q;
      ct_d       = ct_q;
      if (busy_q) begin
         if (k_q == 5'd0) begin
            a_d = a_q + s_rd_data;
         end else if (k_q == 5'd1) begin
            b_d = b_q + s_rd_data;
         end else if (k_q[0] == 1'b0) begin
            a_d = rot_out_s + s_rd_data;
         end else begin
            b_d = rot_out_s + s_rd_data;
         end
         if (k_q == K_LAST) begin
            busy_d     = 1'b0;
            ct_valid_d = 1'b1;
            ct_d       = {b_d, a_d};
         end else begin
            k_d = k_q + 5'd1;
         end
      end else if (enc_start) begin
         busy_d     = 1'b1;
         ct_valid_d = 1'b0;
         k_d        = 5'd0;
         a_d        = pt[7:0];
         b_d        = pt[15:8];
      end else begin
         busy_d = 1'b0;
      end
   end

   // Encryptor registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy_q     <= 1'b0;
         ct_valid_q <= 1'b0;
         k_q        <= 5'd0;
         a_q        <= 8'h00;
         b_q        <= 8'h00;
         ct_q       <= 16'h0000;
      end else begin
         busy_q     <= busy_d;
         ct_valid_q <= ct_valid_d;
         k_q        <= k_d;
         a_q        <= a_d;
         b_q        <= b_d;
         ct_q       <= ct_d;
      end
   end

   assign s_rd_addr = k_q;
   assign enc_busy  = busy_q;
   assign ct_valid  = ct_valid_q;
   assign ct        = ct_q;

endmodule

// File: rtl/rc5_rotl8.sv
// Combinational 8-bit rotate-left by a 3-bit amount; amount 0 passes through.
module rc5_rotl8 (
   input  logic [7:0] din,
   input  logic [2:0] amt,
   output logic [7:0] dout
);

   logic [15:0] dbl_s;

   // Shift a doubled copy so the bits leaving the top re-enter at the bottom.
   always_comb begin
      dbl_s = {din, din} << amt;
      dout  = dbl_s[15:8];
   end

endmodule

// File: rtl/rc5_key_expand_16bit.sv
// RC5-8 key schedule: fills a 26-entry subkey register table from the secret
// key, one INIT write or one MIX iteration per clock.
module rc5_key_expand_16bit
   import rc5_pkg::*;
#(
   parameter int ROUNDS    = rc5_pkg::ROUNDS,
   parameter int KEY_BYTES = rc5_pkg::KEY_BYTES
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   key_start,
   input  logic [8*KEY_BYTES-1:0] key,
   output logic                   key_busy,
   output logic                   key_valid,
   input  logic [4:0]             s_rd_addr,
   output logic [7:0]             s_rd_data
);

   localparam int TN    = 2 * (ROUNDS + 1);
   localparam int CN    = KEY_BYTES;
   localparam int MIX_N = 3 * ((TN > CN) ? TN : CN);
   localparam int JW    = (CN > 1) ? $clog2(CN) : 1;

   localparam logic [4:0]    I_LAST   = 5'(TN - 1);
   localparam logic [JW-1:0] J_LAST   = JW'(CN - 1);
   localparam logic [7:0]    CNT_LAST = 8'(MIX_N - 1);

   key_state_e    state_q, state_d;
   logic [4:0]    i_q, i_d;
   logic [JW-1:0] j_q, j_d;
   logic [7:0]    a_q, a_d;
   logic [7:0]    b_q, b_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [7:0]    l_q [CN];
   logic [7:0]    l_d [CN];
   logic [7:0]    s_q [TN];
   logic [7:0]    s_d [TN];

   logic [7:0]    init_val_s;
   logic [7:0]    a_sum_s, a_rot_s;
   logic [7:0]    b_sum_s, b_rot_s;
   logic [2:0]    b_amt_s;

   // MIX datapath; B uses the freshly rotated A of the same cycle.
   always_comb begin
      init_val_s = P8 + 8'({3'b000, i_q} * Q8);
      a_sum_s    = s_q[i_q] + a_q + b_q;
      b_sum_s    = l_q[j_q] + a_rot_s + b_q;
      b_amt_s    = a_rot_s[2:0] + b_q[2:0];
   end

   rc5_rotl8 u_rotl_a (
      .din  (a_sum_s),
      .amt  (3'd3),
      .dout (a_rot_s)
   );

   rc5_rotl8 u_rotl_b (
      .din  (b_sum_s),
      .amt  (b_amt_s),
      .dout (b_rot_s)
   );

   // Next-state and table update logic.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      l_d     = l_q;
      s_d     = s_q;
      case (state_q)
         IDLE, DONE: begin
            if (key_start) begin
               for (int jj = 0; jj < CN; jj++) begin
                  l_d[jj] = key[8*jj +: 8];
               end
               i_d     = 5'd0;
               j_d     = '0;
               a_d     = 8'h00;
               b_d     = 8'h00;
               cnt_d   = 8'h00;
               state_d = INIT;
            end else begin
               state_d = state_q;
            end
         end
         INIT: begin
            s_d[i_q] = init_val_s;
            if (i_q == I_LAST) begin
               i_d     = 5'd0;
               state_d = MIX;
            end else begin
               i_d = i_q + 5'd1;
            end
         end
         MIX: begin
            s_d[i_q] = a_rot_s;
            l_d[j_q] = b_rot_s;
            a_d      = a_rot_s;
            b_d      = b_rot_s;
            i_d      = (i_q == I_LAST) ? 5'd0 : i_q + 5'd1;
            j_d      = (j_q == J_LAST) ? '0 : j_q + JW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, index, working-word and table registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         i_q     <= 5'd0;
         j_q     <= '0;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         cnt_q   <= 8'h00;
         for (int n = 0; n < CN; n++) begin
            l_q[n] <= 8'h00;
         end
         for (int n = 0; n < TN; n++) begin
            s_q[n] <= 8'h00;
         end
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         l_q     <= l_d;
         s_q     <= s_d;
      end
   end

   assign key_busy  = (state_q == INIT) || (state_q == MIX);
   assign key_valid = (state_q == DONE);

   // Combinational read port; addresses past the table read as zero.
   always_comb begin
      if ({1'b0, s_rd_addr} < 6'(TN)) begin
         s_rd_data = s_q[s_rd_addr];
      end else begin
         s_rd_data = 8'h00;
      end
   end

endmodule

// File: tb/tb_rc5_key_expand_16bit.sv
// Scoreboard bench for rc5_key_expand_16bit with an attached rc5_enc_16bit.
module tb_rc5_key_expand_16bit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        key_start = 1'b0;
   logic [31:0] key = 32'h0;
   logic        key_busy, key_valid;
   logic [4:0]  tb_addr = 5'd0;
   logic [4:0]  enc_addr, mux_addr;
   logic [7:0]  s_rd_data;
   logic        enc_start = 1'b0;
   logic [15:0] pt = 16'h0;
   logic        enc_busy, ct_valid;
   logic [15:0] ct;

   assign mux_addr = enc_busy ? enc_addr : tb_addr;

   rc5_key_expand_16bit #(.ROUNDS(12), .KEY_BYTES(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .key_start (key_start),
      .key       (key),
      .key_busy  (key_busy),
      .key_valid (key_valid),
      .s_rd_addr (mux_addr),
      .s_rd_data (s_rd_data)
   );

   rc5_enc_16bit #(.NR(12)) u_enc (
      .clock     (clock),
      .reset     (reset),
      .enc_start (enc_start),
      .pt        (pt),
      .s_rd_addr (enc_addr),
      .s_rd_data (s_rd_data),
      .enc_busy  (enc_busy),
      .ct_valid  (ct_valid),
      .ct        (ct)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [1:0] kind;   // 0: read data, 1: {busy,valid}, 2: ct_valid level
      logic [4:0] addr;
      logic [7:0] exp;
   } item_t;

   item_t       sb_q [$];
   int          lat_q [$];
   logic [15:0] ct_q [$];
   logic        chk_req = 1'b0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic        valid_prev = 1'b0;
   logic        ctv_prev = 1'b0;

   logic [7:0]  m_s [26];
   logic [15:0] m_ct;

   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: compares whatever the DUT presents against the queued expectations.
   always @(negedge clock) begin
      item_t it;
      int    e;
      logic [15:0] ec;
      if (chk_req) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow: check requested with no expectation");
         end else begin
            it = sb_q.pop_front();
            if (it.kind == 2'd0) begin
               if (s_rd_data !== it.exp) begin
                  errors++;
                  $display("FAIL s_rd[%0d] actual=%02h required=%02h", it.addr, s_rd_data, it.exp);
               end
            end else if (it.kind == 2'd1) begin
               if ({key_busy, key_valid} !== it.exp[1:0]) begin
                  errors++;
                  $display("FAIL status busy,valid actual=%b required=%b", {key_busy, key_valid}, it.exp[1:0]);
               end
            end else begin
               if (ct_valid !== it.exp[0]) begin
                  errors++;
                  $display("FAIL ct_valid actual=%b required=%b", ct_valid, it.exp[0]);
               end
            end
         end
      end
      if (key_valid && !valid_prev) begin
         checks++;
         if (lat_q.size() == 0) begin
            errors++;
            $display("FAIL key_valid_unexpected at cycle %0d", cyc);
         end else begin
            e = lat_q.pop_front();
            if (cyc != e) begin
               errors++;
               $display("FAIL key_valid_latency actual_cycle=%0d required_cycle=%0d", cyc, e);
            end
         end
      end
      if (ct_valid && !ctv_prev) begin
         checks++;
         if (ct_q.size() == 0) begin
            errors++;
            $display("FAIL ct_unexpected actual=%04h", ct);
         end else begin
            ec = ct_q.pop_front();
            if (ct !== ec) begin
               errors++;
               $display("FAIL ciphertext actual=%04h required=%04h", ct, ec);
            end
         end
      end
      valid_prev = key_valid;
      ctv_prev   = ct_valid;
   end

   function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
      logic [7:0] r;
      int m;
      m = n % 8;
      if (m == 0) r = x;
      else r = (x << m) | (x >> (8 - m));
      return r;
   endfunction

   // Software RC5-8 key schedule, written straight from the algorithm.
   task automatic model_expand(input logic [31:0] k);
      logic [7:0] l [4];
      logic [7:0] a, b, v, t, ab;
      int i, j;
      v = 8'hB7;
      for (int n = 0; n < 26; n++) begin
         m_s[n] = v;
         v = v + 8'h9F;
      end
      for (int n = 0; n < 4; n++) l[n] = k[8*n +: 8];
      a = 8'h00; b = 8'h00; i = 0; j = 0;
      for (int n = 0; n < 78; n++) begin
         t = m_s[i] + a + b;
         a = rol8(t, 3);
         m_s[i] = a;
         t = l[j] + a + b;
         ab = a + b;
         b = rol8(t, int'(ab));
         l[j] = b;
         i = (i + 1) % 26;
         j = (j + 1) % 4;
      end
   endtask

   task automatic model_encrypt(input logic [15:0] p);
      logic [7:0] a, b;
      a = p[7:0] + m_s[0];
      b = p[15:8] + m_s[1];
      for (int r = 1; r <= 12; r++) begin
         a = rol8(a ^ b, int'(b)) + m_s[2*r];
         b = rol8(b ^ a, int'(a)) + m_s[2*r+1];
      end
      m_ct = {b, a};
   endtask

   task automatic next_win();
      @(posedge clock);
      #1;
      chk_req = 1'b0;
   endtask

   task automatic push_rd(input logic [4:0] addr, input logic [7:0] exp);
      tb_addr = addr;
      sb_q.push_back('{kind: 2'd0, addr: addr, exp: exp});
      chk_req = 1'b1;
      next_win();
   endtask

   task automatic push_st(input logic busy, input logic valid);
      sb_q.push_back('{kind: 2'd1, addr: 5'd0, exp: {6'b0, busy, valid}});
      chk_req = 1'b1;
      next_win();
   endtask

   task automatic start_key(input logic [31:0] k, input bit track);
      key = k;
      key_start = 1'b1;
      if (track) lat_q.push_back(cyc + 1 + 104);
      next_win();
      key_start = 1'b0;
   endtask

   task automatic wait_valid();
      for (int n = 0; n < 150 && !key_valid; n++) next_win();
      if (!key_valid) push_st(1'b0, 1'b1);
   endtask

   task automatic check_table();
      for (int a = 0; a < 26; a++) push_rd(5'(a), m_s[a]);
   endtask

   task automatic check_zero_table();
      for (int a = 0; a < 26; a++) push_rd(5'(a), 8'h00);
   endtask

   initial begin
      // Reset with a simultaneous key_start: reset must win.
      reset = 1'b1;
      key_start = 1'b1;
      key = 32'hFFFFFFFF;
      repeat (3) next_win();
      reset = 1'b0;
      key_start = 1'b0;
      push_st(1'b0, 1'b0);
      check_zero_table();

      // All-zero key: busy on the start edge, valid at +104, full table.
      start_key(32'h00000000, 1'b1);
      push_st(1'b1, 1'b0);
      wait_valid();
      model_expand(32'h00000000);
      check_table();
      push_rd(5'd26, 8'h00);
      push_rd(5'd31, 8'h00);

      // Probe INIT values before MIX reaches each entry.
      start_key(32'h03020100, 1'b1);
      repeat (25) next_win();
      push_rd(5'd0, 8'hB7);
      push_rd(5'd1, 8'h56);
      push_rd(5'd25, 8'h3E);
      wait_valid();
      model_expand(32'h03020100);
      check_table();

      // key_start while busy with a different key is ignored.
      start_key(32'hA5C30F96, 1'b1);
      repeat (49) next_win();
      key = 32'hFFFFFFFF;
      key_start = 1'b1;
      next_win();
      key_start = 1'b0;
      wait_valid();
      model_expand(32'hA5C30F96);
      check_table();

      // Reset during MIX aborts and clears the table.
      start_key(32'hDEADBEEF, 1'b0);
      repeat (59) next_win();
      reset = 1'b1;
      next_win();
      reset = 1'b0;
      push_st(1'b0, 1'b0);
      check_zero_table();

      // Rekey from DONE, then encrypt 0x0000 with the new table.
      start_key(32'h03020100, 1'b1);
      wait_valid();
      start_key(32'h12345678, 1'b1);
      push_st(1'b1, 1'b0);
      wait_valid();
      model_expand(32'h12345678);
      check_table();
      model_encrypt(16'h0000);
      pt = 16'h0000;
      enc_start = 1'b1;
      ct_q.push_back(m_ct);
      next_win();
      enc_start = 1'b0;
      for (int n = 0; n < 60 && !ct_valid; n++) next_win();
      if (!ct_valid) begin
         sb_q.push_back('{kind: 2'd2, addr: 5'd0, exp: 8'h01});
         chk_req = 1'b1;
         next_win();
      end
      repeat (3) next_win();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
